// File: rtl/apu_run_ctrl_pkg.sv
// Shared APU defines: run-state encodings, counter width and IPC register constants.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
// The IPC status readback decodes apu_run_ctrl state from the same encodings.
package apu_run_ctrl_pkg;

  localparam int APU_CNT_W   = 8;
  localparam int APU_STATE_W = 3;

  typedef enum logic [APU_STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_RST_HOLD  = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_DRAIN     = 3'd4
  } apu_state_e;

  // IPC register map constants (word offsets and bit positions).
  localparam logic [3:0] IPC_REG_CTRL_OFS     = 4'h0;
  localparam logic [3:0] IPC_REG_STATUS_OFS   = 4'h4;
  localparam int         IPC_CTRL_START_BIT   = 0;
  localparam int         IPC_CTRL_STOP_BIT    = 1;
  localparam int         IPC_STATUS_STATE_LSB = 0;

  // Core clock runs in every state except OFF.
  function automatic logic apu_clk_en_of(input apu_state_e s);
    return (s == ST_RST_HOLD) || (s == ST_RUN) ||
           (s == ST_STOP_WAIT) || (s == ST_DRAIN);
  endfunction

  // Core is out of reset only while running or waiting for it to halt.
  function automatic logic apu_rst_n_of(input apu_state_e s);
    return (s == ST_RUN) || (s == ST_STOP_WAIT);
  endfunction

  function automatic logic apu_busy_of(input apu_state_e s);
    return (s == ST_RST_HOLD) || (s == ST_STOP_WAIT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/apu_run_ctrl.sv
// Run-state sequencer driving APU core reset and clock enable from IPC start/stop pulses.
// Latency: all outputs registered, one clock after the sampled event; start -> rst_n release in 1+RESET_HOLD_CYCLES.
// Backpressure: none; requests are single-cycle pulses, ignored in states that do not accept them.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start_req         one-cycle start pulse
//   i_stop_req          one-cycle stop pulse
//   i_apu_halted        level, core quiescent
//   o_apu_rst_n         core reset (active-low), registered
//   o_apu_clk_en        core clock enable, registered
//   o_running / o_busy  RUN / (RST_HOLD|STOP_WAIT|DRAIN) status
//   o_stopped_pulse     one cycle on leaving DRAIN
//   o_timeout_pulse     one cycle when the stop wait expires without halt
//   o_state             current state encoding
module apu_run_ctrl
  import apu_run_ctrl_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int STOP_TIMEOUT      = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start_req,
  input  logic                   i_stop_req,
  input  logic                   i_apu_halted,
  output logic                   o_apu_rst_n,
  output logic                   o_apu_clk_en,
  output logic                   o_running,
  output logic                   o_busy,
  output logic                   o_stopped_pulse,
  output logic                   o_timeout_pulse,
  output logic [APU_STATE_W-1:0] o_state
);

  localparam logic [APU_CNT_W-1:0] LP_HOLD_LOAD = APU_CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [APU_CNT_W-1:0] LP_STOP_LOAD = APU_CNT_W'(STOP_TIMEOUT - 1);

  apu_state_e           r_state;
  logic [APU_CNT_W-1:0] r_cnt;
  logic                 r_pending;
  logic                 r_apu_rst_n;
  logic                 r_apu_clk_en;
  logic                 r_running;
  logic                 r_busy;
  logic                 r_stopped_pulse;
  logic                 r_timeout_pulse;

  apu_state_e           w_nxt_state;
  logic [APU_CNT_W-1:0] w_nxt_cnt;
  logic                 w_nxt_pending;
  logic                 w_stopped;
  logic                 w_timeout;

  always_comb begin
    w_nxt_state   = ST_OFF;
    w_nxt_cnt     = r_cnt;
    w_nxt_pending = r_pending;
    w_stopped     = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_nxt_pending = 1'b0;
        // Simultaneous start+stop: stop wins, stay off.
        if (i_start_req && !i_stop_req) begin
          w_nxt_state = ST_RST_HOLD;
          w_nxt_cnt   = LP_HOLD_LOAD;
        end else begin
          w_nxt_state = ST_OFF;
        end
      end
      ST_RST_HOLD: begin
        if (i_stop_req) begin
          w_nxt_state = ST_DRAIN;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_state = ST_RST_HOLD;
          w_nxt_cnt   = r_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop_req) begin
          w_nxt_state = ST_STOP_WAIT;
          w_nxt_cnt   = LP_STOP_LOAD;
        end else begin
          w_nxt_state = ST_RUN;
        end
      end
      ST_STOP_WAIT: begin
        w_nxt_pending = r_pending | i_start_req;
        // Halt takes priority over expiry, so no timeout is flagged in that cycle.
        if (i_apu_halted) begin
          w_nxt_state = ST_DRAIN;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_DRAIN;
          w_timeout   = 1'b1;
        end else begin
          w_nxt_state = ST_STOP_WAIT;
          w_nxt_cnt   = r_cnt - 1'b1;
        end
      end
      ST_DRAIN: begin
        // Single cycle of reset with clock running; a start seen during the
        // stop sequence (including this cycle) restarts straight away.
        w_stopped     = 1'b1;
        w_nxt_pending = 1'b0;
        if (r_pending || i_start_req) begin
          w_nxt_state = ST_RST_HOLD;
          w_nxt_cnt   = LP_HOLD_LOAD;
        end else begin
          w_nxt_state = ST_OFF;
        end
      end
      default: begin
        // Illegal encodings fall back to OFF.
        w_nxt_state   = ST_OFF;
        w_nxt_cnt     = '0;
        w_nxt_pending = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_OFF;
      r_cnt           <= '0;
      r_pending       <= 1'b0;
      r_apu_rst_n     <= 1'b0;
      r_apu_clk_en    <= 1'b0;
      r_running       <= 1'b0;
      r_busy          <= 1'b0;
      r_stopped_pulse <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_cnt           <= w_nxt_cnt;
      r_pending       <= w_nxt_pending;
      r_apu_rst_n     <= apu_rst_n_of(w_nxt_state);
      r_apu_clk_en    <= apu_clk_en_of(w_nxt_state);
      r_running       <= (w_nxt_state == ST_RUN);
      r_busy          <= apu_busy_of(w_nxt_state);
      r_stopped_pulse <= w_stopped;
      r_timeout_pulse <= w_timeout;
    end
  end

  assign o_apu_rst_n     = r_apu_rst_n;
  assign o_apu_clk_en    = r_apu_clk_en;
  assign o_running       = r_running;
  assign o_busy          = r_busy;
  assign o_stopped_pulse = r_stopped_pulse;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_state         = r_state;

endmodule

// File: tb/tb_apu_run_ctrl.sv
// Directed bench for apu_run_ctrl with RESET_HOLD_CYCLES=8, STOP_TIMEOUT=4.
// Each step drives one cycle of inputs and queues the outputs expected after the edge.
// Expected vectors are popped and compared #1 after the clock edge.
module tb_apu_run_ctrl;
  import apu_run_ctrl_pkg::*;

  localparam int RH = 8;
  localparam int ST = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       rst_n;
    logic       clk_en;
    logic       run;
    logic       busy;
    logic       sp;
    logic       tp;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       halted = 1'b0;
  logic       apu_rst_n, apu_clk_en, running, busy, stopped_pulse, timeout_pulse;
  logic [2:0] state;

  int    n_checks = 0;
  int    n_err    = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  apu_run_ctrl #(.RESET_HOLD_CYCLES(RH), .STOP_TIMEOUT(ST)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start_req    (start_req),
    .i_stop_req     (stop_req),
    .i_apu_halted   (halted),
    .o_apu_rst_n    (apu_rst_n),
    .o_apu_clk_en   (apu_clk_en),
    .o_running      (running),
    .o_busy         (busy),
    .o_stopped_pulse(stopped_pulse),
    .o_timeout_pulse(timeout_pulse),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  // Expected output vector written from the state table: OFF 0, RST_HOLD 1, RUN 2, STOP_WAIT 3, DRAIN 4.
  function automatic obs_t mk(input int s, input logic sp, input logic tp);
    obs_t e;
    e.st     = 3'(s);
    e.clk_en = (s != 0);
    e.rst_n  = (s == 2) || (s == 3);
    e.run    = (s == 2);
    e.busy   = (s == 1) || (s == 3) || (s == 4);
    e.sp     = sp;
    e.tp     = tp;
    return e;
  endfunction

  task automatic drain_q();
    obs_t  o, e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {state, apu_rst_n, apu_clk_en, running, busy, stopped_pulse, timeout_pulse};
      n_checks++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed=%b expected=%b (state,rst_n,clk_en,running,busy,stopped,timeout)", t, o, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input int s);
    exp_q.push_back(mk(s, 1'b0, 1'b0));
    tag_q.push_back(tag);
    drain_q();
  endtask

  // Drive one cycle of inputs; queue the outputs expected after the edge.
  task automatic step(input logic s, input logic p, input logic h,
                      input int es, input logic sp, input logic tp, input string tag);
    start_req = s;
    stop_req  = p;
    halted    = h;
    exp_q.push_back(mk(es, sp, tp));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    drain_q();
  endtask

  task automatic go_run(input string tag);
    step(1, 0, 0, 1, 0, 0, {tag, "_start"});
    for (int i = 0; i < RH - 1; i++) step(0, 0, 0, 1, 0, 0, {tag, "_hold"});
    step(0, 0, 0, 2, 0, 0, {tag, "_run"});
  endtask

  initial begin
    // Reset state, held across edges.
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_hold", 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, "post_reset");

    // Start latency: clk_en at cycle 1, rst_n/running at cycle 1+RH.
    go_run("start");
    step(1, 0, 0, 2, 0, 0, "run_ignores_start");

    // Stop with core already halted.
    step(0, 1, 1, 3, 0, 0, "stop_h_wait");
    step(0, 0, 1, 4, 0, 0, "stop_h_drain");
    step(0, 0, 1, 0, 1, 0, "stop_h_off_pulse");
    step(0, 0, 1, 0, 0, 0, "stop_h_pulse_end");

    // Stop timeout with core never halting.
    go_run("to");
    step(0, 1, 0, 3, 0, 0, "to_wait");
    for (int i = 0; i < ST - 1; i++) step(0, 0, 0, 3, 0, 0, "to_wait_cnt");
    step(0, 0, 0, 4, 0, 1, "to_drain_pulse");
    step(0, 0, 0, 0, 1, 0, "to_off");
    step(0, 0, 0, 0, 0, 0, "to_idle");

    // Halt arrives in the same cycle the counter expires: no timeout pulse.
    go_run("tie");
    step(0, 1, 0, 3, 0, 0, "tie_wait");
    for (int i = 0; i < ST - 2; i++) step(0, 0, 0, 3, 0, 0, "tie_wait_cnt");
    step(0, 0, 0, 3, 0, 0, "tie_wait_last");
    step(0, 0, 1, 4, 0, 0, "tie_drain_no_to");
    step(0, 0, 0, 0, 1, 0, "tie_off");

    // Start during STOP_WAIT restarts directly after DRAIN.
    go_run("rs");
    step(0, 1, 0, 3, 0, 0, "rs_wait");
    step(1, 0, 0, 3, 0, 0, "rs_wait_pend");
    step(0, 0, 1, 4, 0, 0, "rs_drain");
    step(0, 0, 0, 1, 1, 0, "rs_hold_pulse");
    for (int i = 0; i < RH - 1; i++) step(0, 0, 0, 1, 0, 0, "rs_hold");
    step(0, 0, 0, 2, 0, 0, "rs_run");
    step(0, 1, 1, 3, 0, 0, "rs_stop_wait");
    step(0, 0, 1, 4, 0, 0, "rs_stop_drain");
    step(0, 0, 1, 0, 1, 0, "rs_stop_off");

    // Simultaneous start+stop in OFF, then stop during RST_HOLD.
    step(1, 1, 0, 0, 0, 0, "both_off");
    step(0, 0, 0, 0, 0, 0, "both_off_idle");
    step(1, 0, 0, 1, 0, 0, "rh_start");
    step(0, 0, 0, 1, 0, 0, "rh_hold");
    step(0, 1, 0, 4, 0, 0, "rh_stop_drain");
    step(0, 0, 0, 0, 1, 0, "rh_off");
    step(0, 0, 0, 0, 0, 0, "rh_idle");

    // Asynchronous reset mid-RUN.
    go_run("ar");
    #2 rst = 1'b1;
    #1 check_now("arst_run_async", 0);
    @(posedge clk);
    #1 check_now("arst_run_held", 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, "arst_run_after");

    // Asynchronous reset mid-STOP_WAIT with a pending start discarded.
    go_run("aw");
    step(0, 1, 0, 3, 0, 0, "aw_wait");
    step(1, 0, 0, 3, 0, 0, "aw_pend");
    start_req = 1'b0;
    #2 rst = 1'b1;
    #1 check_now("arst_wait_async", 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 1, 0, 0, 0, "arst_no_restart");
    step(0, 0, 1, 0, 0, 0, "arst_still_off");
    step(1, 0, 0, 1, 0, 0, "arst_restart_ok");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apu_run_ctrl.md
# apu_run_ctrl

Run-state sequencer for the APU core. Consumes the one-cycle start/stop requests decoded by the APU IPC register block and drives the APU core's reset and clock enable through a fixed power-on and power-down sequence. Reports completion and stop-timeout events as single-cycle pulses for the interrupt logic. Sits between the IPC registers and the APU core wrapper, in the APU clock domain.

## Interface

Parameters:
- RESET_HOLD_CYCLES, default 8: cycles of reset applied to the APU core with its clock running before release; legal range 1–255.
- STOP_TIMEOUT, default 255: cycles to wait for `apu_halted` after a stop request before forcing reset; legal range 1–255.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start_req  input  1  one-cycle start pulse from IPC registers.
- stop_req  input  1  one-cycle stop pulse from IPC registers.
- apu_halted  input  1  APU core is quiescent (WFI/halt); level.
- apu_rst_n  output  1  APU core reset, active-low; registered.
- apu_clk_en  output  1  APU core clock enable; registered.
- running  output  1  high in RUN only.
- busy  output  1  high in RST_HOLD, STOP_WAIT or DRAIN.
- stopped_pulse  output  1  one-cycle pulse on entry to OFF from DRAIN.
- timeout_pulse  output  1  one-cycle pulse when the stop timeout expires.
- state  output  3  current state encoding, for status readback.

## Operation

- States and encodings: OFF=0, RST_HOLD=1, RUN=2, STOP_WAIT=3, DRAIN=4.
- OFF: apu_clk_en=0, apu_rst_n=0.
  - start_req → RST_HOLD; load the counter with RESET_HOLD_CYCLES-1.
  - stop_req is ignored.
  - If start_req and stop_req are both high, stop wins and the state stays OFF.
- RST_HOLD: apu_clk_en=1, apu_rst_n=0.
  - Counter decrements each cycle; at 0 → RUN.
  - stop_req → DRAIN immediately.
  - start_req is ignored.
- RUN: apu_clk_en=1, apu_rst_n=1.
  - stop_req → STOP_WAIT; load the counter with STOP_TIMEOUT-1.
  - start_req is ignored.
- STOP_WAIT: apu_clk_en=1, apu_rst_n=1.
  - apu_halted=1 → DRAIN.
  - Otherwise the counter decrements; at 0 with apu_halted=0 → DRAIN and timeout_pulse=1 for one cycle.
  - apu_halted wins over timeout expiry in the same cycle, so no timeout_pulse is raised.
  - start_req sets the pending_start flag.
- DRAIN: apu_clk_en=1, apu_rst_n=0, held for exactly one cycle so reset propagates with the clock running; then → OFF and stopped_pulse=1.
  - If pending_start is set, the next state is RST_HOLD instead of OFF (counter reloaded), pending_start clears, and stopped_pulse still fires.
  - start_req seen in DRAIN also sets pending_start.
- Counter: 8-bit down-counter shared by RST_HOLD and STOP_WAIT; never underflows, and is reloaded on every state entry that uses it.
- Invalid state encodings recover to OFF on the next clock.

## Timing

- Reset value (while rst=1 and after release): state=OFF, apu_rst_n=0, apu_clk_en=0, running=0, busy=0, stopped_pulse=0, timeout_pulse=0, pending_start=0, counter=0.
- rst asserted mid-operation forces the reset values asynchronously, with no DRAIN cycle.
- All outputs are registered and change on the clock edge after the cycle in which the event is sampled. There is no combinational path from input to output.
- Start latency: start_req high in cycle 0 → apu_clk_en=1 from cycle 1 → apu_rst_n=1 from cycle 1+RESET_HOLD_CYCLES.
- Stop latency with the core already halted: stop_req in cycle 0 → STOP_WAIT in cycle 1 → DRAIN (apu_rst_n=0) in cycle 2 → OFF with stopped_pulse in cycle 3.
- Timeout: stop_req in cycle 0 with apu_halted held low → DRAIN and timeout_pulse in cycle 1+STOP_TIMEOUT.
- Pulses are one cycle wide. Back-to-back request pulses are each evaluated in their own cycle.

## Structure

- State encodings (3-bit) and counter width (8) go in the shared APU defines header, together with the IPC register constants, so the IPC status readback decodes `state` from the same source.
- Implementation is a single flat module: one state register, one 8-bit counter, one pending_start flag, and registered outputs decoded from the next-state value. A separate counter sub-module is not warranted.

## Test plan

- Reset then start_req at cycle 0 with RESET_HOLD_CYCLES=8 → apu_clk_en rises at cycle 1, apu_rst_n rises at cycle 9, running=1 from cycle 9.
- In RUN, stop_req with apu_halted=1 → apu_rst_n falls at cycle 2, apu_clk_en falls at cycle 3, stopped_pulse=1 at cycle 3 only, state=0.
- In RUN, stop_req with apu_halted=0 and STOP_TIMEOUT=4 → timeout_pulse=1 at cycle 5, DRAIN then OFF at cycle 6; check the same-cycle case where apu_halted=1 at expiry gives no timeout_pulse.
- start_req during STOP_WAIT → after DRAIN the state goes directly to RST_HOLD (apu_clk_en stays high), stopped_pulse fires once, and RUN is re-entered RESET_HOLD_CYCLES cycles later.
- start_req and stop_req high in the same cycle in OFF → state stays OFF; stop_req during RST_HOLD → DRAIN next cycle, apu_rst_n never rises.
- Assert rst mid-RUN and mid-STOP_WAIT → all outputs take reset values immediately with no pulse; any pending_start is discarded.
